// File: rtl/exe_unit_pkg.sv
// Shared types and width helpers for the SPI execution unit count sequencer.
package exe_unit_pkg;

    // Count opcodes as delivered by the SPI command decoder
    typedef enum logic [1:0] {
        CNT_ZERO   = 2'b00,
        CNT_ONE    = 2'b01,
        LEAD_ZERO  = 2'b10,
        TRAIL_ZERO = 2'b11
    } op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SCAN = 2'b01,
        DONE = 2'b10
    } state_e;

    // Widths for the default operand width of 8
    localparam int DEF_BITS = 8;
    localparam int SCAN_W   = 2 * DEF_BITS;
    localparam int CNT_W    = $clog2(SCAN_W + 1);
    localparam int IDX_W    = $clog2(SCAN_W);

    // Width helpers for an arbitrary operand width
    function automatic int scan_w(input int bits);
        return 2 * bits;
    endfunction

    function automatic int cnt_w(input int bits);
        return $clog2(2 * bits + 1);
    endfunction

    function automatic int idx_w(input int bits);
        return $clog2(2 * bits);
    endfunction

    // Zero-search ops stop early on the first 1 bit
    function automatic logic is_seek_op(input op_e op);
        return (op == LEAD_ZERO) || (op == TRAIL_ZERO);
    endfunction

endpackage

// File: rtl/zliczanie_scan_dp.sv
// Scan datapath: latched word, up/down bit index, bit mux and count incrementer.
module zliczanie_scan_dp
    import exe_unit_pkg::*;
#(
    parameter  int BITS = 8,
    localparam int SW   = scan_w(BITS),
    localparam int CW   = cnt_w(BITS),
    localparam int IW   = idx_w(BITS)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_load,
    input  logic          i_step,
    input  op_e           i_op,
    input  logic [SW-1:0] i_word,
    output op_e           o_op,
    output logic          o_bit_hit,
    output logic          o_last_bit,
    output logic [CW-1:0] o_count_nxt
);

    logic [SW-1:0] word_q, word_d;
    logic [IW-1:0] idx_q,  idx_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    op_e           op_q,   op_d;

    logic cur_bit;
    logic descending;
    logic last_bit;
    logic inc;

    assign cur_bit    = word_q[idx_q];
    assign descending = (op_q == LEAD_ZERO);
    assign last_bit   = descending ? (idx_q == '0) : (idx_q == IW'(SW - 1));
    // CNT_ONE counts ones; every other op counts zeros (a 1 ends a zero search)
    assign inc        = (op_q == CNT_ONE) ? cur_bit : ~cur_bit;

    // Next-state of the word, index and count registers
    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        if (i_load) begin
            word_d = i_word;
            op_d   = i_op;
            cnt_d  = '0;
            idx_d  = (i_op == LEAD_ZERO) ? IW'(SW - 1) : '0;
        end else if (i_step) begin
            if (inc) begin
                cnt_d = cnt_q + CW'(1);
            end
            // Index parks at the word end instead of wrapping
            if (!last_bit) begin
                idx_d = descending ? (idx_q - IW'(1)) : (idx_q + IW'(1));
            end
        end
    end

    // Datapath registers, cleared on reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            op_q   <= CNT_ZERO;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
        end
    end

    assign o_op        = op_q;
    assign o_bit_hit   = cur_bit;
    assign o_last_bit  = last_bit;
    assign o_count_nxt = cnt_d;

endmodule

// File: rtl/zliczanie_seq.sv
// Bit-serial zero/one/leading/trailing count sequencer with valid/ready on both sides.
module zliczanie_seq
    import exe_unit_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [1:0]      i_op,
    input  logic [BITS-1:0] i_argA,
    input  logic [BITS-1:0] i_argB,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [BITS-1:0] o_result,
    output logic            o_busy
);

    localparam int CW = cnt_w(BITS);

    state_e          state_q, state_d;
    logic [BITS-1:0] result_q, result_d;

    logic          load;
    logic          step;
    op_e           run_op;
    logic          bit_hit;
    logic          last_bit;
    logic [CW-1:0] count_nxt;

    assign load = (state_q == IDLE) && i_valid;
    assign step = (state_q == SCAN);

    zliczanie_scan_dp #(
        .BITS (BITS)
    ) u_scan_dp (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_load      (load),
        .i_step      (step),
        .i_op        (op_e'(i_op)),
        .i_word      ({i_argA, i_argB}),
        .o_op        (run_op),
        .o_bit_hit   (bit_hit),
        .o_last_bit  (last_bit),
        .o_count_nxt (count_nxt)
    );

    // Next-state and result capture; the result only changes on entry to DONE
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if ((is_seek_op(run_op) && bit_hit) || last_bit) begin
                    state_d  = DONE;
                    result_d = BITS'(count_nxt);
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
        end
    end

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_busy   = (state_q != IDLE);
    assign o_result = result_q;

endmodule

// File: doc/zliczanie_seq.md
Name: zliczanie_seq

Overview:
- Bit-serial sequencer for the zero/one-count operation of the SPI execution unit.
- Accepts an operand pair plus a count opcode from the SPI command decoder over a valid/ready handshake.
- Scans the concatenation {i_argA,i_argB} one bit per clock and returns the count over a second valid/ready handshake.
- Replaces the 16-wide combinational adder chain with one incrementer and a small FSM.

Parameters:
- BITS, 8: operand width and result width. Scanned word is 2*BITS wide. Constraint: BITS >= 4, so that a count of 2*BITS fits in BITS bits.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  request valid
- o_ready  out  1  request accepted when i_valid && o_ready
- i_op  in  2  opcode: 00 CNT_ZERO, 01 CNT_ONE, 10 LEAD_ZERO (from MSB), 11 TRAIL_ZERO (from LSB)
- i_argA  in  BITS  upper half of scanned word
- i_argB  in  BITS  lower half of scanned word
- o_valid  out  1  result valid
- i_ready  in  1  result consumed when o_valid && i_ready
- o_result  out  BITS  count, zero-extended
- o_busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous assert, any state): state=IDLE, o_result=0, o_valid=0, o_busy=0, o_ready=1, internal word/index/count cleared. An operation in flight is discarded and produces no result.
- States: IDLE, SCAN, DONE. o_ready=1 only in IDLE. o_valid=1 only in DONE.
- IDLE, on handshake:
  - Latch word={i_argA,i_argB} and op.
  - Clear count.
  - Set index to 2*BITS-1 for LEAD_ZERO; 0 for all other ops.
  - Go to SCAN.
- SCAN, one bit per clock at the current index:
  - CNT_ZERO: count+1 if bit==0. CNT_ONE: count+1 if bit==1. Exactly 2*BITS SCAN cycles, index ascending.
  - LEAD_ZERO: index descending. TRAIL_ZERO: index ascending. On bit==0, count+1. On bit==1, go to DONE immediately without incrementing (early termination).
  - After the last bit (index 2*BITS-1 ascending, or 0 descending), go to DONE.
- Latency, with the accept edge at E0:
  - Popcount ops: o_valid rises after edge E0+2*BITS.
  - LEAD_ZERO/TRAIL_ZERO with k zeros before the first 1: o_valid rises after edge E0+k+1.
  - All-zero word: result is 2*BITS after 2*BITS SCAN cycles.
- DONE:
  - o_result holds the count and stays stable while o_valid=1 && i_ready=0.
  - On i_ready go to IDLE. o_valid drops on the next edge; o_result keeps its last value until the next DONE.
- i_valid while not IDLE: ignored (o_ready=0). The requester must hold i_op/args until accepted. No back-to-back accept in the DONE→IDLE cycle.
- Input changes after accept do not affect the running operation.
- i_ready while not in DONE: ignored.
- Width rules:
  - count is clog2(2*BITS+1) bits, zero-extended to BITS.
  - index is clog2(2*BITS) bits.
  - No wrap-around: index never steps past the word ends.

Decomposition:
- Shared package exe_unit_pkg: opcode enum (CNT_ZERO, CNT_ONE, LEAD_ZERO, TRAIL_ZERO), FSM state enum (IDLE, SCAN, DONE), width helper localparams (SCAN_W=2*BITS, CNT_W, IDX_W).
- One natural sub-module: zliczanie_scan_dp. Holds the word register, index up/down counter, bit mux and count incrementer, and emits bit_hit and last_bit to the FSM in the top module.

Test Plan (BITS=8):
- CNT_ZERO, A=0x00, B=0x00 → o_valid 16 cycles after accept, o_result=16. Then A=0xF0, B=0x0F → 8.
- CNT_ONE, A=0xFF, B=0x01 → o_result=9 after 16 cycles. A=0xFF, B=0xFF → 16.
- LEAD_ZERO, A=0x00, B=0x10 → o_result=11, o_valid after 12 cycles. A=0x80 → 0 after 1 cycle. All zeros → 16 after 16 cycles.
- TRAIL_ZERO, A=0x80, B=0x00 → o_result=15 after 16 cycles. B=0x01 → 0 after 1 cycle.
- Backpressure: hold i_ready=0 for 5 cycles in DONE → o_valid and o_result stable. A new i_valid during that time is not accepted (o_ready=0). Accepted only after the return to IDLE.
- Reset: assert i_rst_n=0 mid-SCAN (cycle 7 of CNT_ZERO) → all outputs immediately at reset values. After release, o_ready=1, no stale o_valid, and the next op returns the correct count.
